// File: rtl/sc_level_pkg.sv
// Shared state encoding and speed-period arithmetic for the Frogger level sequencer.
package sc_level_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_BANNER = 2'd2;
  localparam logic [1:0] ST_WON    = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StPlay   = ST_PLAY,
    StBanner = ST_BANNER,
    StWon    = ST_WON
  } state_e;

  // max(base - (level-1)*step, min_period); a negative difference clamps to min_period.
  function automatic logic [63:0] calc_period(input logic [63:0] level, input logic [63:0] base,
                                              input logic [63:0] step,
                                              input logic [63:0] min_period);
    logic [63:0] dec;
    logic [63:0] diff;
    dec  = (level == 64'd0) ? 64'd0 : (level - 64'd1) * step;
    diff = base - dec;
    if (dec > base || diff < min_period) begin
      return min_period;
    end
    return diff;
  endfunction

endpackage

// File: rtl/sc_falling_edge_sync.sv
// Two-flop synchroniser for an active-low request, producing one registered pulse per
// high-to-low transition.
module sc_falling_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_ni,
  output logic fall_o
);

  logic       sync1_q, sync2_q;
  logic       armed_q;
  logic [1:0] fill_q;
  logic       fall_q;

  // armed_q only rises once a genuinely sampled high has passed through the synchroniser,
  // so an input already low when reset is released cannot fake an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= in_ni;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= fill_q[1] & sync2_q;
      fall_q  <= armed_q & ~sync2_q;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/sc_level_sequencer.sv
// Frogger level sequencer: edge-detected start/done requests drive level, banner, win flag
// and a per-level speed tick.
module sc_level_sequencer
  import sc_level_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH   = 4,
  parameter int unsigned MAX_LEVEL     = 9,
  parameter int unsigned WRAP_MODE     = 0,
  parameter int unsigned BANNER_CYCLES = 50_000_000,
  parameter int unsigned PERIOD_WIDTH  = 26,
  parameter int unsigned BASE_PERIOD   = 25_000_000,
  parameter int unsigned PERIOD_STEP   = 2_000_000,
  parameter int unsigned MIN_PERIOD    = 2_000_000
) (
  input  logic                   SC_COUNTER_LEVELS_CLOCK_50,
  input  logic                   SC_COUNTER_LEVELS_RESET_InHigh,
  input  logic                   SC_COUNTER_LEVELS_start_InLow,
  input  logic                   SC_COUNTER_LEVELS_done_InLow,
  output logic [LEVEL_WIDTH-1:0] SC_COUNTER_LEVELS_level_Out,
  output logic                   SC_COUNTER_LEVELS_levelUp_OutHigh,
  output logic                   SC_COUNTER_LEVELS_banner_OutHigh,
  output logic                   SC_COUNTER_LEVELS_won_OutHigh,
  output logic                   SC_COUNTER_LEVELS_tick_OutHigh
);

  localparam int unsigned BannerWidth = $clog2(BANNER_CYCLES + 1);
  localparam logic [LEVEL_WIDTH-1:0] LevelOne = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0] LevelMax = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [BannerWidth-1:0] BannerLoad = BannerWidth'(BANNER_CYCLES - 1);

  // Tick counter load value: it counts down to zero, so one less than the period.
  function automatic logic [PERIOD_WIDTH-1:0] reload_of(input logic [LEVEL_WIDTH-1:0] lvl);
    return PERIOD_WIDTH'(calc_period(64'(lvl), 64'(BASE_PERIOD), 64'(PERIOD_STEP),
                                     64'(MIN_PERIOD))) - PERIOD_WIDTH'(1);
  endfunction

  logic start_ev, done_ev;

  sc_falling_edge_sync u_start_sync (
    .clk_i  (SC_COUNTER_LEVELS_CLOCK_50),
    .rst_i  (SC_COUNTER_LEVELS_RESET_InHigh),
    .in_ni  (SC_COUNTER_LEVELS_start_InLow),
    .fall_o (start_ev)
  );

  sc_falling_edge_sync u_done_sync (
    .clk_i  (SC_COUNTER_LEVELS_CLOCK_50),
    .rst_i  (SC_COUNTER_LEVELS_RESET_InHigh),
    .in_ni  (SC_COUNTER_LEVELS_done_InLow),
    .fall_o (done_ev)
  );

  state_e                  state_q, state_d;
  logic [LEVEL_WIDTH-1:0]  level_q, level_d;
  logic [BannerWidth-1:0]  banner_q, banner_d;
  logic [PERIOD_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic                    level_up_q, level_up_d;
  logic                    won_pulse_q, won_pulse_d;
  logic                    tick_q, tick_d;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    banner_d    = banner_q;
    tick_cnt_d  = tick_cnt_q;
    level_up_d  = 1'b0;
    won_pulse_d = 1'b0;
    tick_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ev) begin
          state_d    = StPlay;
          level_d    = LevelOne;
          tick_cnt_d = reload_of(LevelOne);
        end
      end
      StPlay: begin
        // Start wins over a simultaneous done.
        if (start_ev) begin
          level_d    = LevelOne;
          tick_cnt_d = reload_of(LevelOne);
        end else if (done_ev) begin
          if (level_q < LevelMax) begin
            level_d    = level_q + LevelOne;
            level_up_d = 1'b1;
            state_d    = StBanner;
            banner_d   = BannerLoad;
          end else if (WRAP_MODE != 0) begin
            level_d     = LevelOne;
            won_pulse_d = 1'b1;
            state_d     = StBanner;
            banner_d    = BannerLoad;
          end else begin
            state_d = StWon;
          end
        end else if (tick_cnt_q == '0) begin
          tick_d     = 1'b1;
          tick_cnt_d = reload_of(level_q);
        end else begin
          tick_cnt_d = tick_cnt_q - PERIOD_WIDTH'(1);
        end
      end
      StBanner: begin
        if (banner_q == '0) begin
          state_d    = StPlay;
          tick_cnt_d = reload_of(level_q);
        end else begin
          banner_d = banner_q - BannerWidth'(1);
        end
      end
      StWon: begin
        if (start_ev) begin
          state_d    = StPlay;
          level_d    = LevelOne;
          tick_cnt_d = reload_of(LevelOne);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SC_COUNTER_LEVELS_CLOCK_50 or posedge SC_COUNTER_LEVELS_RESET_InHigh) begin
    if (SC_COUNTER_LEVELS_RESET_InHigh) begin
      state_q     <= StIdle;
      level_q     <= '0;
      banner_q    <= '0;
      tick_cnt_q  <= '0;
      level_up_q  <= 1'b0;
      won_pulse_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      banner_q    <= banner_d;
      tick_cnt_q  <= tick_cnt_d;
      level_up_q  <= level_up_d;
      won_pulse_q <= won_pulse_d;
      tick_q      <= tick_d;
    end
  end

  assign SC_COUNTER_LEVELS_level_Out       = level_q;
  assign SC_COUNTER_LEVELS_levelUp_OutHigh = level_up_q;
  assign SC_COUNTER_LEVELS_banner_OutHigh  = (state_q == StBanner);
  assign SC_COUNTER_LEVELS_won_OutHigh     = (WRAP_MODE == 0) ? (state_q == StWon) : won_pulse_q;
  assign SC_COUNTER_LEVELS_tick_OutHigh    = tick_q;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Bench for sc_level_sequencer: stop-at-win and wrap variants share one stimulus stream and
// are each checked every cycle against a time-based model, plus directed literal checks.
module tb_sc_level_sequencer;

  localparam int Base   = 10;
  localparam int Step   = 4;
  localparam int MinPer = 3;
  localparam int MaxLvl = 3;
  localparam int Banner = 4;

  localparam int MIdle = 0, MPlay = 1, MBanner = 2, MWon = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_n = 1'b1;
  logic done_n = 1'b1;

  logic [3:0] lvl0, lvl1;
  logic lu0, bn0, won0, tk0;
  logic lu1, bn1, won1, tk1;

  always #5 clk = ~clk;

  sc_level_sequencer #(
    .LEVEL_WIDTH(4), .MAX_LEVEL(MaxLvl), .WRAP_MODE(0), .BANNER_CYCLES(Banner),
    .PERIOD_WIDTH(26), .BASE_PERIOD(Base), .PERIOD_STEP(Step), .MIN_PERIOD(MinPer)
  ) u_dut0 (
    .SC_COUNTER_LEVELS_CLOCK_50        (clk),
    .SC_COUNTER_LEVELS_RESET_InHigh    (rst),
    .SC_COUNTER_LEVELS_start_InLow     (start_n),
    .SC_COUNTER_LEVELS_done_InLow      (done_n),
    .SC_COUNTER_LEVELS_level_Out       (lvl0),
    .SC_COUNTER_LEVELS_levelUp_OutHigh (lu0),
    .SC_COUNTER_LEVELS_banner_OutHigh  (bn0),
    .SC_COUNTER_LEVELS_won_OutHigh     (won0),
    .SC_COUNTER_LEVELS_tick_OutHigh    (tk0)
  );

  sc_level_sequencer #(
    .LEVEL_WIDTH(4), .MAX_LEVEL(MaxLvl), .WRAP_MODE(1), .BANNER_CYCLES(Banner),
    .PERIOD_WIDTH(26), .BASE_PERIOD(Base), .PERIOD_STEP(Step), .MIN_PERIOD(MinPer)
  ) u_dut1 (
    .SC_COUNTER_LEVELS_CLOCK_50        (clk),
    .SC_COUNTER_LEVELS_RESET_InHigh    (rst),
    .SC_COUNTER_LEVELS_start_InLow     (start_n),
    .SC_COUNTER_LEVELS_done_InLow      (done_n),
    .SC_COUNTER_LEVELS_level_Out       (lvl1),
    .SC_COUNTER_LEVELS_levelUp_OutHigh (lu1),
    .SC_COUNTER_LEVELS_banner_OutHigh  (bn1),
    .SC_COUNTER_LEVELS_won_OutHigh     (won1),
    .SC_COUNTER_LEVELS_tick_OutHigh    (tk1)
  );

  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: cycle-indexed, with absolute times for the next tick and the banner end.
  int       m_n[2], m_ns[2], m_mode[2], m_lvl[2], m_next_tick[2], m_banner_end[2];
  bit [3:0] m_sh[2], m_dh[2];
  bit       m_lu[2], m_wonp[2], m_tick[2];

  function automatic int per(input int l);
    int p;
    p = Base - (l - 1) * Step;
    return (p < MinPer) ? MinPer : p;
  endfunction

  task automatic model_reset(input int i);
    m_n[i] = 0; m_ns[i] = 0; m_mode[i] = MIdle; m_lvl[i] = 0;
    m_next_tick[i] = 0; m_banner_end[i] = 0;
    m_sh[i] = '1; m_dh[i] = '1;
    m_lu[i] = 0; m_wonp[i] = 0; m_tick[i] = 0;
  endtask

  task automatic model_step(input int i, input bit wrap, input bit s_in, input bit d_in);
    bit sev, dev;
    m_n[i]++;
    // A low sample acts three edges later, only if the sample before it was a real high.
    sev = (m_ns[i] >= 4) && !m_sh[i][2] && m_sh[i][3];
    dev = (m_ns[i] >= 4) && !m_dh[i][2] && m_dh[i][3];
    m_sh[i] = {m_sh[i][2:0], s_in};
    m_dh[i] = {m_dh[i][2:0], d_in};
    m_ns[i]++;
    m_lu[i] = 0; m_wonp[i] = 0; m_tick[i] = 0;
    case (m_mode[i])
      MIdle, MWon: if (sev) begin
        m_mode[i] = MPlay; m_lvl[i] = 1; m_next_tick[i] = m_n[i] + per(1);
      end
      MPlay: begin
        if (sev) begin
          m_lvl[i] = 1; m_next_tick[i] = m_n[i] + per(1);
        end else if (dev) begin
          if (m_lvl[i] < MaxLvl) begin
            m_lvl[i]++; m_lu[i] = 1;
            m_mode[i] = MBanner; m_banner_end[i] = m_n[i] + Banner;
          end else if (wrap) begin
            m_lvl[i] = 1; m_wonp[i] = 1;
            m_mode[i] = MBanner; m_banner_end[i] = m_n[i] + Banner;
          end else begin
            m_mode[i] = MWon;
          end
        end else if (m_n[i] == m_next_tick[i]) begin
          m_tick[i] = 1; m_next_tick[i] = m_n[i] + per(m_lvl[i]);
        end
      end
      default: if (m_n[i] == m_banner_end[i]) begin
        m_mode[i] = MPlay; m_next_tick[i] = m_n[i] + per(m_lvl[i]);
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, 1'b0, start_n, done_n);
      model_step(1, 1'b1, start_n, done_n);
    end
  end

  always @(negedge clk) begin
    chk("m0_level", int'(lvl0), m_lvl[0]);
    chk("m0_levelup", int'(lu0), int'(m_lu[0]));
    chk("m0_banner", int'(bn0), int'(m_mode[0] == MBanner));
    chk("m0_won", int'(won0), int'(m_mode[0] == MWon));
    chk("m0_tick", int'(tk0), int'(m_tick[0]));
    chk("m1_level", int'(lvl1), m_lvl[1]);
    chk("m1_levelup", int'(lu1), int'(m_lu[1]));
    chk("m1_banner", int'(bn1), int'(m_mode[1] == MBanner));
    chk("m1_won", int'(won1), int'(m_wonp[1]));
    chk("m1_tick", int'(tk1), int'(m_tick[1]));
  end

  task automatic measure_gap(input int want, input string name);
    int t0, t1;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 60 && t1 < 0; i++) begin
      @(negedge clk);
      if (tk0) begin
        if (t0 < 0) t0 = i;
        else t1 = i;
      end
    end
    chk(name, (t1 < 0) ? -1 : t1 - t0, want);
  endtask

  task automatic pulse_done();
    @(negedge clk) done_n = 1'b0;
    @(negedge clk) done_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start_n = 1'b0;
    @(negedge clk) start_n = 1'b1;
  endtask

  int first, changes, prev, lu_cnt, bn_cnt, w1_cnt, bn1_cnt, wt_cnt;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_level0", int'(lvl0), 0);
    chk("rst_banner0", int'(bn0), 0);
    chk("rst_level1", int'(lvl1), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_level", int'(lvl0), 0);

    // Start held low 20 cycles.
    start_n = 1'b0;
    first = 0; changes = 0; prev = int'(lvl0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (int'(lvl0) != prev) begin
        changes++;
        if (first == 0) first = i;
      end
      prev = int'(lvl0);
    end
    start_n = 1'b1;
    chk("start_latency", first, 4);
    chk("start_once", changes, 1);
    chk("level_after_start", int'(lvl0), 1);
    measure_gap(10, "gap_l1");

    // Done at L1, plus a second done landing inside the banner.
    @(negedge clk) done_n = 1'b0;
    @(negedge clk) done_n = 1'b1;
    @(negedge clk) done_n = 1'b0;
    @(negedge clk) done_n = 1'b1;
    lu_cnt = 0; bn_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      lu_cnt += int'(lu0);
      bn_cnt += int'(bn0);
    end
    chk("l1_levelup_cycles", lu_cnt, 1);
    chk("l1_banner_cycles", bn_cnt, 4);
    chk("level_after_done", int'(lvl0), 2);
    measure_gap(6, "gap_l2");

    pulse_done();
    repeat (12) @(negedge clk);
    chk("level_l3", int'(lvl0), 3);
    measure_gap(3, "gap_l3");

    // Done at the last level: stop in WON vs. wrap to 1.
    pulse_done();
    w1_cnt = 0; bn1_cnt = 0; wt_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      w1_cnt += int'(won1);
      bn1_cnt += int'(bn1);
      wt_cnt += int'(won0 & tk0);
    end
    chk("won_stop", int'(won0), 1);
    chk("won_level", int'(lvl0), 3);
    chk("won_no_ticks", wt_cnt, 0);
    chk("wrap_won_cycles", w1_cnt, 1);
    chk("wrap_banner_cycles", bn1_cnt, 4);
    chk("wrap_level", int'(lvl1), 1);

    pulse_start();
    repeat (6) @(negedge clk);
    chk("restart_level", int'(lvl0), 1);
    chk("restart_won", int'(won0), 0);
    measure_gap(10, "gap_resume");

    // Start and done falling together at L2.
    pulse_done();
    repeat (10) @(negedge clk);
    chk("pre_both_level", int'(lvl0), 2);
    @(negedge clk) begin start_n = 1'b0; done_n = 1'b0; end
    @(negedge clk) begin start_n = 1'b1; done_n = 1'b1; end
    lu_cnt = 0; bn_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      lu_cnt += int'(lu0);
      bn_cnt += int'(bn0);
    end
    chk("both_levelup", lu_cnt, 0);
    chk("both_banner", bn_cnt, 0);
    chk("both_level", int'(lvl0), 1);

    // Reset mid-banner with both inputs held low.
    pulse_done();
    repeat (4) @(negedge clk);
    chk("mid_banner", int'(bn0), 1);
    start_n = 1'b0; done_n = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_level0", int'(lvl0), 0);
    chk("async_rst_banner0", int'(bn0), 0);
    chk("async_rst_level1", int'(lvl1), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_event_after_rst", int'(lvl0), 0);
    start_n = 1'b1; done_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("rearm_after_rst", int'(lvl0), 1);

    // Random traffic, with rare resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start_n = ($urandom_range(0, 29) != 0);
      done_n  = ($urandom_range(0, 4) != 0);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 799) == 0) #2 rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; start_n = 1'b1; done_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
